// File: rtl/reg_bank_mux.sv
// Register bank with one write port and NUM_READ registered read ports.
// Each read port can forward same-cycle write data and can hardwire entry 0 to zero.

module reg_bank_rd_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_entry,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    logic [DATA_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // Later assignments win: the zero entry overrides any forwarded write.
    always_comb begin
        w_sel = i_entry;
        if (BYPASS != 0 && i_wr_en && i_wr_addr == i_addr)
            w_sel = i_wr_data;
        if (ZERO_REG != 0 && i_addr == '0)
            w_sel = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en)
                r_data <= w_sel;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

module reg_bank_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           wr_en_in,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_in,
    input  logic [DATA_WIDTH-1:0]          wr_data_in,
    input  logic [NUM_READ-1:0]            rd_en_in,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_in,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_out,
    output logic [NUM_READ-1:0]            rd_valid_out
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0]    r_mem;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] w_entry;
    logic                                w_wr_ok;

    assign w_wr_ok = wr_en_in && !(ZERO_REG != 0 && wr_addr_in == '0);

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_mem <= '0;
        else if (w_wr_ok)
            r_mem[wr_addr_in] <= wr_data_in;
    end

    // One lane per read port; storage lookup is shared, selection and output regs are per lane.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        assign w_entry[p] = r_mem[rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]];

        reg_bank_rd_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_lane (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .i_en      (rd_en_in[p]),
            .i_addr    (rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_entry   (w_entry[p]),
            .i_wr_en   (wr_en_in),
            .i_wr_addr (wr_addr_in),
            .i_wr_data (wr_data_in),
            .o_data    (rd_data_out[p*DATA_WIDTH +: DATA_WIDTH]),
            .o_valid   (rd_valid_out[p])
        );
    end
endmodule

// File: tb/tb_reg_bank_mux.sv
// Bench for reg_bank_mux: default config (bypass, zero entry) plus a 4-port 64-bit
// config with both options off; directed table, hand sequences, then random vs model.
module tb_reg_bank_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DATA_WIDTH=32, NUM_READ=2, ZERO_REG=1, BYPASS=1
    logic        a_rst, a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [1:0]  a_ren, a_rv;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;

    // DUT B: DATA_WIDTH=64, NUM_READ=4, ZERO_REG=0, BYPASS=0
    logic         b_rst, b_we;
    logic [4:0]   b_wa;
    logic [63:0]  b_wd;
    logic [3:0]   b_ren, b_rv;
    logic [19:0]  b_ra;
    logic [255:0] b_rd;

    reg_bank_mux #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk_in(clk), .rst_in(a_rst), .wr_en_in(a_we), .wr_addr_in(a_wa), .wr_data_in(a_wd),
        .rd_en_in(a_ren), .rd_addr_in(a_ra), .rd_data_out(a_rd), .rd_valid_out(a_rv));

    reg_bank_mux #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(4), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk_in(clk), .rst_in(b_rst), .wr_en_in(b_we), .wr_addr_in(b_wa), .wr_data_in(b_wd),
        .rd_en_in(b_ren), .rd_addr_in(b_ra), .rd_data_out(b_rd), .rd_valid_out(b_rv));

    int total = 0;
    int bad   = 0;

    // Reference model: storage arrays plus the expected output registers.
    logic [31:0] ma [32];
    logic [63:0] mb [32];
    logic [31:0] ea_d [2];
    logic [1:0]  ea_v;
    logic [63:0] eb_d [4];
    logic [3:0]  eb_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Expected outputs come from the pre-edge contents; storage is updated afterwards.
    task automatic model_step();
        int ad;
        for (int p = 0; p < 2; p++) begin
            ad = int'(a_ra[p*5 +: 5]);
            if (a_rst) begin
                ea_d[p] = '0; ea_v[p] = 1'b0;
            end else if (a_ren[p]) begin
                ea_v[p] = 1'b1;
                if (ad == 0)                       ea_d[p] = '0;
                else if (a_we && int'(a_wa) == ad) ea_d[p] = a_wd;
                else                               ea_d[p] = ma[ad];
            end else begin
                ea_v[p] = 1'b0;
            end
        end
        for (int p = 0; p < 4; p++) begin
            ad = int'(b_ra[p*5 +: 5]);
            if (b_rst) begin
                eb_d[p] = '0; eb_v[p] = 1'b0;
            end else begin
                eb_v[p] = b_ren[p];
                if (b_ren[p]) eb_d[p] = mb[ad];
            end
        end
        if (a_rst) begin
            for (int i = 0; i < 32; i++) ma[i] = '0;
        end else if (a_we && a_wa != 5'd0) begin
            ma[a_wa] = a_wd;
        end
        if (b_rst) begin
            for (int i = 0; i < 32; i++) mb[i] = '0;
        end else if (b_we) begin
            mb[b_wa] = b_wd;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_model_d%0d", p), {32'd0, a_rd[p*32 +: 32]}, {32'd0, ea_d[p]});
        end
        chk("a_model_v", {62'd0, a_rv}, {62'd0, ea_v});
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("b_model_d%0d", p), b_rd[p*64 +: 64], eb_d[p]);
        end
        chk("b_model_v", {60'd0, b_rv}, {60'd0, eb_v});
    endtask

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  ev;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    function automatic vec_t mk(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [1:0] ren, logic [4:0] ra0, logic [4:0] ra1,
                                logic [1:0] ev, logic [31:0] e0, logic [31:0] e1);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ren = ren;
        v.ra0 = ra0; v.ra1 = ra1; v.ev = ev; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    function automatic logic [63:0] pat(int i);
        logic [7:0] b;
        b = 8'(i);
        return {8{b}} ^ 64'hF0E1_D2C3_B4A5_9687;
    endfunction

    vec_t tbl [19];

    initial begin
        for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; end
        for (int p = 0; p < 2; p++) ea_d[p] = '0;
        for (int p = 0; p < 4; p++) eb_d[p] = '0;
        ea_v = '0; eb_v = '0;

        //            rst we  wa    wd            ren    ra0   ra1   ev     e0            e1
        tbl[0]  = mk(1, 0, 5'd0,  32'h0,        2'b00, 5'd0, 5'd0,  2'b00, 32'h0,        32'h0);
        tbl[1]  = mk(1, 0, 5'd0,  32'h0,        2'b00, 5'd0, 5'd0,  2'b00, 32'h0,        32'h0);
        tbl[2]  = mk(0, 0, 5'd0,  32'h0,        2'b11, 5'd5, 5'd31, 2'b11, 32'h0,        32'h0);
        tbl[3]  = mk(0, 1, 5'd7,  32'hDEADBEEF, 2'b00, 5'd0, 5'd0,  2'b00, 32'h0,        32'h0);
        tbl[4]  = mk(0, 0, 5'd0,  32'h0,        2'b01, 5'd7, 5'd0,  2'b01, 32'hDEADBEEF, 32'h0);
        tbl[5]  = mk(0, 1, 5'd9,  32'h12345678, 2'b11, 5'd9, 5'd9,  2'b11, 32'h12345678, 32'h12345678);
        tbl[6]  = mk(0, 0, 5'd0,  32'h0,        2'b11, 5'd9, 5'd7,  2'b11, 32'h12345678, 32'hDEADBEEF);
        tbl[7]  = mk(0, 1, 5'd0,  32'hFFFFFFFF, 2'b11, 5'd0, 5'd0,  2'b11, 32'h0,        32'h0);
        tbl[8]  = mk(0, 0, 5'd0,  32'h0,        2'b01, 5'd0, 5'd0,  2'b01, 32'h0,        32'h0);
        tbl[9]  = mk(0, 0, 5'd0,  32'h0,        2'b01, 5'd7, 5'd0,  2'b01, 32'hDEADBEEF, 32'h0);
        tbl[10] = mk(0, 1, 5'd7,  32'h1,        2'b00, 5'd7, 5'd7,  2'b00, 32'hDEADBEEF, 32'h0);
        tbl[11] = mk(0, 1, 5'd7,  32'h1,        2'b00, 5'd7, 5'd7,  2'b00, 32'hDEADBEEF, 32'h0);
        tbl[12] = mk(0, 1, 5'd7,  32'h1,        2'b00, 5'd7, 5'd7,  2'b00, 32'hDEADBEEF, 32'h0);
        tbl[13] = mk(0, 0, 5'd0,  32'h0,        2'b01, 5'd7, 5'd0,  2'b01, 32'h1,        32'h0);
        tbl[14] = mk(0, 1, 5'd3,  32'h55,       2'b11, 5'd3, 5'd3,  2'b11, 32'h55,       32'h55);
        tbl[15] = mk(0, 0, 5'd0,  32'h0,        2'b11, 5'd3, 5'd3,  2'b11, 32'h55,       32'h55);
        tbl[16] = mk(1, 0, 5'd0,  32'h0,        2'b11, 5'd3, 5'd3,  2'b00, 32'h0,        32'h0);
        tbl[17] = mk(0, 0, 5'd0,  32'h0,        2'b11, 5'd3, 5'd3,  2'b11, 32'h0,        32'h0);
        tbl[18] = mk(0, 1, 5'd31, 32'hA5A5A5A5, 2'b10, 5'd0, 5'd31, 2'b10, 32'h0,        32'hA5A5A5A5);

        b_rst = 1'b1; b_we = 1'b0; b_wa = '0; b_wd = '0; b_ren = '0; b_ra = '0;

        for (int i = 0; i < 19; i++) begin
            a_rst = tbl[i].rst; a_we = tbl[i].we; a_wa = tbl[i].wa; a_wd = tbl[i].wd;
            a_ren = tbl[i].ren; a_ra = {tbl[i].ra1, tbl[i].ra0};
            b_rst = tbl[i].rst;
            tick();
            chk($sformatf("v%0d_valid", i), {62'd0, a_rv}, {62'd0, tbl[i].ev});
            chk($sformatf("v%0d_d0", i), {32'd0, a_rd[31:0]}, {32'd0, tbl[i].e0});
            chk($sformatf("v%0d_d1", i), {32'd0, a_rd[63:32]}, {32'd0, tbl[i].e1});
        end

        // Bypass off and zero entry off, 4 ports of 64 bits.
        a_rst = 1'b0; a_we = 1'b0; a_ren = '0;
        b_rst = 1'b1; tick();
        chk("b_rst_valid", {60'd0, b_rv}, 64'd0);
        chk("b_rst_data", b_rd[63:0], 64'd0);
        b_rst = 1'b0; b_we = 1'b1; b_wa = 5'd9; b_wd = 64'hAAAA0000; tick();
        b_wd = 64'h12345678; b_ren = 4'b0011; b_ra = {5'd0, 5'd0, 5'd9, 5'd9}; tick();
        chk("b_nobypass_d0", b_rd[0 +: 64], 64'hAAAA0000);
        chk("b_nobypass_d1", b_rd[64 +: 64], 64'hAAAA0000);
        chk("b_nobypass_valid", {60'd0, b_rv}, 64'h3);
        b_we = 1'b0; b_ren = 4'b0001; tick();
        chk("b_next_read9", b_rd[0 +: 64], 64'h12345678);
        b_we = 1'b1; b_wa = 5'd0; b_wd = 64'hFFFFFFFF; b_ren = '0; tick();
        b_we = 1'b0; b_ren = 4'b0001; b_ra = '0; tick();
        chk("b_zero_off", b_rd[0 +: 64], 64'hFFFFFFFF);
        for (int i = 1; i <= 4; i++) begin
            b_we = 1'b1; b_wa = 5'(i); b_wd = pat(i); b_ren = '0; tick();
        end
        b_we = 1'b0; b_ren = 4'hF; b_ra = {5'd4, 5'd3, 5'd2, 5'd1}; tick();
        for (int p = 0; p < 4; p++) chk($sformatf("b_port%0d_pat", p), b_rd[p*64 +: 64], pat(p + 1));
        chk("b_all_valid", {60'd0, b_rv}, 64'hF);

        // Random traffic with addresses clustered so bypass/zero/same-address cases recur.
        for (int c = 0; c < 1500; c++) begin
            a_rst = ($urandom_range(0, 63) == 0);
            a_we  = 1'($urandom);
            a_wa  = 5'($urandom_range(0, 7));
            a_wd  = $urandom;
            a_ren = 2'($urandom);
            for (int p = 0; p < 2; p++) a_ra[p*5 +: 5] = 5'($urandom_range(0, 7));
            b_rst = ($urandom_range(0, 63) == 0);
            b_we  = 1'($urandom);
            b_wa  = 5'($urandom_range(0, 7));
            b_wd  = {$urandom, $urandom};
            b_ren = 4'($urandom);
            for (int p = 0; p < 4; p++) b_ra[p*5 +: 5] = 5'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
